// File: rtl/apuf_eval_ctrl.sv
// Evaluation sequencer for one adder-based arbiter PUF: repeated discharge/fire/sample races, per-bit majority vote.
// Optional APUF_EVAL_STABILITY_EN adds rsp_unstable, flagging response bits whose evaluations disagreed.
module apuf_eval_ctrl #(
    parameter int CH_W          = 16,
    parameter int RSP_W         = 4,
    parameter int N_EVAL        = 5,
    parameter int PRECHARGE_CYC = 4,
    parameter int SETTLE_CYC    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ch_valid,
    output logic             ch_ready,
    input  logic [CH_W-1:0]  ch_data,
    input  logic             abort,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RSP_W-1:0] rsp_data,
    output logic             busy,
    output logic             puf_pulse,
    output logic [CH_W-1:0]  puf_challenge,
    input  logic [RSP_W-1:0] puf_response
`ifdef APUF_EVAL_STABILITY_EN
    ,
    output logic [RSP_W-1:0] rsp_unstable
`endif
);

    localparam int PH_MAX = (PRECHARGE_CYC > SETTLE_CYC) ? PRECHARGE_CYC : SETTLE_CYC;
    localparam int CW     = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;
    localparam int OW     = $clog2(N_EVAL + 1);

    localparam logic [CW-1:0] PRE_LAST  = CW'(PRECHARGE_CYC - 1);
    localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [OW-1:0] EVAL_LAST = OW'(N_EVAL - 1);
    localparam logic [OW-1:0] HALF      = OW'(N_EVAL / 2);
`ifdef APUF_EVAL_STABILITY_EN
    localparam logic [OW-1:0] ALL_ONES  = OW'(N_EVAL);
`endif

    typedef enum logic [2:0] {IDLE, DISCHARGE, FIRE, SAMPLE, VOTE, DONE} state_e;

    state_e            state_q, state_d;
    logic              init_q;
    logic [CW-1:0]     phase_q;
    logic [OW-1:0]     eval_q;
    logic [OW-1:0]     ones_q [RSP_W];
    logic [CH_W-1:0]   challenge_q;
    logic [RSP_W-1:0]  rsp_data_q;
    logic [RSP_W-1:0]  vote_d;
    logic              accept;
`ifdef APUF_EVAL_STABILITY_EN
    logic [RSP_W-1:0]  unstable_q;
    logic [RSP_W-1:0]  unstable_d;
`endif

    assign accept = ch_valid && ch_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (accept) state_d = DISCHARGE;
            DISCHARGE: if (abort) state_d = IDLE;
                       else if (phase_q == PRE_LAST) state_d = FIRE;
            FIRE:      if (abort) state_d = IDLE;
                       else if (phase_q == SET_LAST) state_d = SAMPLE;
            SAMPLE:    if (abort) state_d = IDLE;
                       else if (eval_q == EVAL_LAST) state_d = VOTE;
                       else state_d = DISCHARGE;
            VOTE:      state_d = abort ? IDLE : DONE;
            DONE:      if (rsp_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // ch_ready is held off until the first edge after reset release via init_q.
    always_comb begin
        ch_ready  = (state_q == IDLE) && init_q;
        busy      = (state_q != IDLE);
        puf_pulse = (state_q == FIRE) || (state_q == SAMPLE);
        rsp_valid = (state_q == DONE);
    end

    always_comb begin
        vote_d = '0;
        for (int i = 0; i < RSP_W; i++) vote_d[i] = (ones_q[i] > HALF);
    end

`ifdef APUF_EVAL_STABILITY_EN
    always_comb begin
        unstable_d = '0;
        for (int i = 0; i < RSP_W; i++)
            unstable_d[i] = (ones_q[i] != '0) && (ones_q[i] != ALL_ONES);
    end
`endif

    // The result registers only load on an un-aborted VOTE, so aborts never disturb the last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b0;
            phase_q     <= '0;
            eval_q      <= '0;
            challenge_q <= '0;
            rsp_data_q  <= '0;
            for (int i = 0; i < RSP_W; i++) ones_q[i] <= '0;
`ifdef APUF_EVAL_STABILITY_EN
            unstable_q  <= '0;
`endif
        end else begin
            init_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        challenge_q <= ch_data;
                        phase_q     <= '0;
                        eval_q      <= '0;
                        for (int i = 0; i < RSP_W; i++) ones_q[i] <= '0;
                    end
                end
                DISCHARGE, FIRE: begin
                    phase_q <= (state_d == state_q) ? phase_q + CW'(1) : '0;
                end
                SAMPLE: begin
                    if (!abort) begin
                        for (int i = 0; i < RSP_W; i++)
                            ones_q[i] <= ones_q[i] + OW'(puf_response[i]);
                        if (eval_q != EVAL_LAST) eval_q <= eval_q + OW'(1);
                    end
                end
                VOTE: begin
                    if (!abort) begin
                        rsp_data_q <= vote_d;
`ifdef APUF_EVAL_STABILITY_EN
                        unstable_q <= unstable_d;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign puf_challenge = challenge_q;
    assign rsp_data      = rsp_data_q;
`ifdef APUF_EVAL_STABILITY_EN
    assign rsp_unstable  = unstable_q;
`endif

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Directed bench for apuf_eval_ctrl: default instance (5 evals, 4/8 cycles) plus a minimal 1/1/1 instance.
// Also checks rsp_unstable when built with APUF_EVAL_STABILITY_EN.
module tb_apuf_eval_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ch_valid, ch_ready, abort, rsp_valid, rsp_ready, busy, puf_pulse;
    logic [15:0] ch_data, puf_challenge;
    logic [3:0]  rsp_data, puf_response;
    logic        chValidS, chReadyS, abortS, rspValidS, rspReadyS, busyS, pulseS;
    logic [15:0] chDataS, challengeS;
    logic [3:0]  rspDataS, respS;
`ifdef APUF_EVAL_STABILITY_EN
    logic [3:0]  rsp_unstable, rspUnstableS;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0]     ch;
        logic [4:0][3:0] seq;
        logic [3:0]      expData;
        logic [3:0]      expUnst;
    } vec_t;

    vec_t vecs [6];

    apuf_eval_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
        .abort(abort), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .puf_pulse(puf_pulse), .puf_challenge(puf_challenge), .puf_response(puf_response)
`ifdef APUF_EVAL_STABILITY_EN
        , .rsp_unstable(rsp_unstable)
`endif
    );

    apuf_eval_ctrl #(.N_EVAL(1), .PRECHARGE_CYC(1), .SETTLE_CYC(1)) dutSmall (
        .clk(clk), .rst_n(rst_n), .ch_valid(chValidS), .ch_ready(chReadyS), .ch_data(chDataS),
        .abort(abortS), .rsp_valid(rspValidS), .rsp_ready(rspReadyS), .rsp_data(rspDataS),
        .busy(busyS), .puf_pulse(pulseS), .puf_challenge(challengeS), .puf_response(respS)
`ifdef APUF_EVAL_STABILITY_EN
        , .rsp_unstable(rspUnstableS)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [15:0] ch, input logic [3:0] s0, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4,
                                input logic [3:0] d, input logic [3:0] u);
        vec_t v;
        v.ch = ch;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
        v.expData = d;
        v.expUnst = u;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (ch_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", 32'(ch_ready), 32'd1);
    endtask

    // Offers a challenge in IDLE and returns at the negedge of the first cycle after the accept edge.
    task automatic applyStimulus(input logic [15:0] ch, input logic [3:0] firstResp);
        waitReady();
        ch_valid     = 1'b1;
        ch_data      = ch;
        puf_response = firstResp;
        @(negedge clk);
        ch_valid = 1'b0;
    endtask

    // Cycle c=1 is the cycle right after accept; eval k spans 13k+1..13k+13, VOTE is 66, DONE is 67.
    task automatic runBody(input logic [15:0] ch, input logic [4:0][3:0] seq, input int lastCycle,
                           input logic [3:0] expData, input logic [3:0] expUnst);
        logic expPulse;
        for (int c = 1; c <= lastCycle; c++) begin
            if (c <= 65 && ((c - 1) % 13) == 0) puf_response = seq[(c - 1) / 13];
            expPulse = (c <= 65) && (((c - 1) % 13) >= 4);
            checkOutput($sformatf("pulse_c%0d", c), 32'(puf_pulse), 32'(expPulse));
            checkOutput($sformatf("rsp_valid_c%0d", c), 32'(rsp_valid), 32'(c == 67));
            if (c == 1 || c == 67) begin
                checkOutput("busy_run", 32'(busy), 32'd1);
                checkOutput("ch_ready_run", 32'(ch_ready), 32'd0);
                checkOutput("challenge_run", 32'(puf_challenge), 32'(ch));
            end
            if (c == 67) begin
                checkOutput("rsp_data", 32'(rsp_data), 32'(expData));
`ifdef APUF_EVAL_STABILITY_EN
                checkOutput("rsp_unstable", 32'(rsp_unstable), 32'(expUnst));
`else
                if (expUnst === 4'hx) checkOutput("unst_placeholder", 32'(expUnst), 32'd0);
`endif
            end
            if (c < lastCycle) @(negedge clk);
        end
    endtask

    task automatic releaseResponse(input logic [3:0] expData);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rel_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rel_ready", 32'(ch_ready), 32'd1);
        checkOutput("rel_busy", 32'(busy), 32'd0);
        checkOutput("rel_data_kept", 32'(rsp_data), 32'(expData));
    endtask

    initial begin
        logic [3:0] prevData;
        logic [3:0] smallResp [2];
        logic       smallPulse [5];

        vecs[0] = mk(16'hA5C3, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000);
        vecs[1] = mk(16'h1111, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        vecs[2] = mk(16'h2222, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        vecs[3] = mk(16'h3333, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111);
        vecs[4] = mk(16'h4444, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0011, 4'b1110, 4'b1111);
        vecs[5] = mk(16'hFFFF, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        rst_n = 1'b0; ch_valid = 1'b0; ch_data = '0; abort = 1'b0; rsp_ready = 1'b0; puf_response = '0;
        chValidS = 1'b0; chDataS = '0; abortS = 1'b0; rspReadyS = 1'b0; respS = '0;

        // Reset values, and ch_ready only after the first edge following release.
        repeat (3) @(negedge clk);
        checkOutput("rst_pulse", 32'(puf_pulse), 32'd0);
        checkOutput("rst_challenge", 32'(puf_challenge), 32'd0);
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(ch_ready), 32'd0);
`ifdef APUF_EVAL_STABILITY_EN
        checkOutput("rst_unstable", 32'(rsp_unstable), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", 32'(ch_ready), 32'd0);
        @(negedge clk);
        checkOutput("ready_after_edge", 32'(ch_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].ch, vecs[v].seq[0]);
            runBody(vecs[v].ch, vecs[v].seq, 67, vecs[v].expData, vecs[v].expUnst);
            releaseResponse(vecs[v].expData);
        end

        // DONE held 10 cycles with a competing challenge offered throughout.
        applyStimulus(16'hBEEF, 4'b0101);
        runBody(16'hBEEF, {5{4'b0101}}, 67, 4'b0101, 4'b0000);
        ch_valid = 1'b1;
        ch_data  = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_data", 32'(rsp_data), 32'h5);
            checkOutput("hold_ready", 32'(ch_ready), 32'd0);
            checkOutput("hold_challenge", 32'(puf_challenge), 32'hBEEF);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("hold_idle_valid", 32'(rsp_valid), 32'd0);
        checkOutput("hold_idle_ready", 32'(ch_ready), 32'd1);
        checkOutput("hold_idle_challenge", 32'(puf_challenge), 32'hBEEF);
        puf_response = 4'b0110;
        @(negedge clk);
        ch_valid = 1'b0;
        checkOutput("second_busy", 32'(busy), 32'd1);
        runBody(16'h1234, {5{4'b0110}}, 67, 4'b0110, 4'b0000);
        releaseResponse(4'b0110);
        prevData = 4'b0110;

        // Abort in the third FIRE phase (cycle 33), then a clean run must not see stale counts.
        applyStimulus(16'h0F0F, 4'b1111);
        runBody(16'h0F0F, {5{4'b1111}}, 33, 4'b0000, 4'b0000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_pulse", 32'(puf_pulse), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ready", 32'(ch_ready), 32'd1);
        checkOutput("abort_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_data_kept", 32'(rsp_data), 32'(prevData));
        applyStimulus(vecs[2].ch, vecs[2].seq[0]);
        runBody(vecs[2].ch, vecs[2].seq, 67, vecs[2].expData, vecs[2].expUnst);
        releaseResponse(vecs[2].expData);

        // Asynchronous reset mid-FIRE.
        applyStimulus(16'h5A5A, 4'b1111);
        runBody(16'h5A5A, {5{4'b1111}}, 20, 4'b0000, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_pulse", 32'(puf_pulse), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_challenge", 32'(puf_challenge), 32'd0);
        checkOutput("arst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("arst_data", 32'(rsp_data), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("arst_valid_hold", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("arst_ready_after", 32'(ch_ready), 32'd1);
        applyStimulus(vecs[4].ch, vecs[4].seq[0]);
        runBody(vecs[4].ch, vecs[4].seq, 67, vecs[4].expData, vecs[4].expUnst);
        releaseResponse(vecs[4].expData);

        // Minimal configuration: DISCHARGE, FIRE, SAMPLE, VOTE, then DONE on cycle 5.
        smallResp[0] = 4'b1011;
        smallResp[1] = 4'b0100;
        smallPulse[0] = 1'b0; smallPulse[1] = 1'b1; smallPulse[2] = 1'b1;
        smallPulse[3] = 1'b0; smallPulse[4] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            checkOutput("small_ready", 32'(chReadyS), 32'd1);
            chValidS = 1'b1;
            chDataS  = 16'hC000 | 16'(t);
            respS    = smallResp[t];
            @(negedge clk);
            chValidS = 1'b0;
            checkOutput("small_challenge", 32'(challengeS), 32'(16'hC000 | 16'(t)));
            for (int c = 1; c <= 5; c++) begin
                checkOutput($sformatf("small_pulse_c%0d", c), 32'(pulseS), 32'(smallPulse[c - 1]));
                checkOutput($sformatf("small_valid_c%0d", c), 32'(rspValidS), 32'(c == 5));
                if (c < 5) @(negedge clk);
            end
            checkOutput("small_data", 32'(rspDataS), 32'(smallResp[t]));
`ifdef APUF_EVAL_STABILITY_EN
            checkOutput("small_unstable", 32'(rspUnstableS), 32'd0);
`endif
            rspReadyS = 1'b1;
            @(negedge clk);
            rspReadyS = 1'b0;
            checkOutput("small_rel_valid", 32'(rspValidS), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apuf_eval_ctrl.md
Name: apuf_eval_ctrl

Overview:
Sequencer for one adder-based arbiter PUF instance (16-bit challenge, 4-bit response).
- Accepts a challenge over a valid/ready handshake and holds it stable on the PUF challenge bus.
- Drives the PUF race pulse through repeated discharge/fire/sample evaluations and majority-votes the sampled responses.
- Returns the voted response over a valid/ready handshake. Sits between the host/test interface and the PUF core.

Parameters:
CH_W, 16, challenge width driven to PUF
RSP_W, 4, response width returned by PUF arbiters
N_EVAL, 5, evaluations per challenge; odd, legal range 1..15
PRECHARGE_CYC, 4, cycles pulse held low before each race; >=1
SETTLE_CYC, 8, cycles pulse held high before sampling; >=1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ch_valid  in  1  challenge offered
ch_ready  out  1  controller can accept challenge
ch_data  in  CH_W  challenge value
abort  in  1  synchronous cancel of the evaluation in progress
rsp_valid  out  1  voted response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  RSP_W  majority-voted response
busy  out  1  high in any state other than IDLE
puf_pulse  out  1  race pulse to PUF (replicated onto adder input A externally)
puf_challenge  out  CH_W  challenge to PUF adder input B
puf_response  in  RSP_W  PUF arbiter outputs

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE. All counters 0.
  - puf_pulse=0, puf_challenge=0, rsp_valid=0, rsp_data=0, busy=0, ch_ready=0 while rst_n=0.
  - ch_ready=1 from the first clk edge after release.
- States: IDLE, DISCHARGE, FIRE, SAMPLE, VOTE, DONE.
- IDLE: ch_ready=1.
  - On ch_valid&ch_ready, latch ch_data into puf_challenge, clear eval counter and per-bit ones counters, go to DISCHARGE.
  - puf_challenge holds its value until the next accept.
- DISCHARGE: puf_pulse=0 for exactly PRECHARGE_CYC cycles, then FIRE.
- FIRE: puf_pulse=1 for exactly SETTLE_CYC cycles, then SAMPLE.
- SAMPLE: one cycle, puf_pulse=1.
  - Register puf_response and, per bit, increment its ones counter if set. Counter width is clog2(N_EVAL+1).
  - If eval count = N_EVAL-1, go to VOTE. Otherwise increment eval count and go to DISCHARGE.
- VOTE: one cycle, puf_pulse=0. rsp_data[i] = (ones[i] > N_EVAL/2, integer division). Go to DONE.
- DONE: rsp_valid=1, puf_pulse=0. rsp_data is stable while rsp_valid=1 and rsp_ready=0. On rsp_ready, go to IDLE and drop rsp_valid the following cycle.
- Latency: ch accept edge to first cycle rsp_valid=1 is 1 + N_EVAL*(PRECHARGE_CYC+SETTLE_CYC+1) + 1 cycles. Defaults give 67.
- No new challenge while busy: ch_ready=0 in every non-IDLE state, including DONE.
- abort:
  - Sampled in DISCHARGE, FIRE, SAMPLE and VOTE: next state IDLE, puf_pulse=0 next cycle, no rsp_valid, rsp_data keeps its previous value.
  - Ignored in IDLE and DONE.
  - abort together with the last SAMPLE cycle: abort wins.
- rst_n low mid-evaluation: immediate return to reset values. No partial response is ever presented.
- puf_response is treated as asynchronous. The bench must hold it stable around the SAMPLE edge. Synchronisation stays inside the PUF arbiter.

Optional Feature:
Macro APUF_EVAL_STABILITY_EN.
- Defined: extra output rsp_unstable [RSP_W], valid with rsp_valid and reset to 0. Bit i=1 when ones[i] is neither 0 nor N_EVAL, i.e. the evaluations disagreed.
- Not defined: port absent, no unanimity logic. All other behaviour is identical.

Test Plan:
- Reset, then ch_data=16'hA5C3 with puf_response constant 4'b1010 -> puf_challenge=16'hA5C3, puf_pulse shows 5 low(4)/high(9) bursts, rsp_valid at accept+67, rsp_data=4'b1010; rsp_unstable=0 when enabled.
- puf_response per SAMPLE = 0001,0001,0000,0001,0000 -> rsp_data=4'b0001; rsp_unstable=4'b0001 when enabled. Repeat with 0001,0000,0000,0001,0000 -> rsp_data=4'b0000.
- rsp_ready held low 10 cycles in DONE, and ch_valid=1 throughout -> rsp_data and rsp_valid stable, ch_ready=0; the second challenge is accepted only the cycle after the IDLE return.
- abort pulsed during the 3rd FIRE phase -> puf_pulse=0 next cycle, IDLE, ch_ready=1, no rsp_valid; a following challenge yields the correct vote with no counter carry-over.
- rst_n dropped mid-FIRE -> puf_pulse, busy and puf_challenge go to 0 asynchronously; rsp_valid stays 0; normal operation after release.
- N_EVAL=1, PRECHARGE_CYC=1, SETTLE_CYC=1 -> rsp_valid at accept+5, rsp_data equals the single sampled response.
